// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter: FSM state and transaction owner.
package riscv_pkg;

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Two-requester arbitration: on a tie the requester not named by ptr wins.
module arb_pick
    import riscv_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_e ptr,
    output logic   gnt_if,
    output logic   gnt_ls
);

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (if_req && ls_req) begin
            if (ptr == OWN_IF) begin
                gnt_ls = 1'b1;
            end else begin
                gnt_if = 1'b1;
            end
        end else begin
            gnt_if = if_req;
            gnt_ls = ls_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (LS) with one
// transaction in flight and a response timeout. Define ARB_RR_EN for round-robin
// arbitration; the default build uses fixed LS priority.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [3:0]    ls_be,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          rerr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           ptr;
    logic             pick_if, pick_ls;
    logic             resp, timeout, issuable, grant;

    // The timeout fires in the cycle the counter would reach TIMEOUT.
    assign resp     = (state_q == BUSY) && mem_rvalid;
    assign timeout  = (state_q == BUSY) && !mem_rvalid && (cnt_q == CNT_LAST);
    assign issuable = rst_n && ((state_q == IDLE) || resp);
    assign grant    = issuable && (pick_if || pick_ls);

`ifdef ARB_RR_EN
    owner_e ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= OWN_IF;
        end else if (grant) begin
            ptr_q <= pick_ls ? OWN_LS : OWN_IF;
        end
    end

    assign ptr = ptr_q;
`else
    // A pointer stuck at IF makes LS win every tie.
    assign ptr = OWN_IF;
`endif

    arb_pick u_pick (
        .if_req (if_req),
        .ls_req (ls_req),
        .ptr    (ptr),
        .gnt_if (pick_if),
        .gnt_ls (pick_ls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (grant) begin
            state_d = BUSY;
            owner_d = pick_ls ? OWN_LS : OWN_IF;
            cnt_d   = '0;
        end else if (resp || timeout) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        rerr      = 1'b0;

        if (issuable && pick_ls) begin
            ls_gnt    = 1'b1;
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (issuable && pick_if) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end

        // A timeout response carries zero data; rerr marks it.
        if (resp) begin
            if (owner_q == OWN_LS) begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end else if (timeout) begin
            rerr = 1'b1;
            if (owner_q == OWN_LS) begin
                ls_rvalid = 1'b1;
            end else begin
                if_rvalid = 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 32, address width; DW, 32, data width; TIMEOUT, 255, max cycles waiting for mem_rvalid (1..255).
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch request accepted.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DW  fetch data.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store.
- ls_be  in  4  byte enables.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_gnt  out  1  load/store request accepted.
- ls_rvalid  out  1  load data or store acknowledge.
- ls_rdata  out  DW  load data.
- rerr  out  1  response is a timeout error; qualifies if_rvalid/ls_rvalid.
- mem_req  out  1  request to the single-port memory.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  AW  address.
- mem_wdata  out  DW  write data.
- mem_rvalid  in  1  memory response (read data or write ack).
- mem_rdata  in  DW  read data.

Function
REQ-003 The arbiter SHALL share one memory port between IF and LS, with at most one transaction outstanding.
REQ-004 FSM states SHALL be IDLE and BUSY.
REQ-005 A request is issuable in IDLE, or in BUSY during the cycle mem_rvalid=1 (back-to-back issue).
REQ-006 On an issuable cycle with any req=1, the arbiter SHALL combinationally assert mem_req, drive the winner's address, write-enable, byte-enable and data, and assert the winner's gnt in the same cycle.
REQ-007 A loser's gnt SHALL be 0; requesters hold req and payload stable until gnt.
REQ-008 IF requests SHALL drive mem_we=0 and mem_be=4'hF.
REQ-009 On a grant, the FSM SHALL enter BUSY and register the owner (IF or LS).
REQ-010 It SHALL return to IDLE on mem_rvalid when nothing new is granted in that cycle.
REQ-011 When mem_rvalid=1 in BUSY, the owner's rvalid=1 and rdata=mem_rdata SHALL be driven combinationally in that cycle, with rerr=0.
REQ-012 Store responses SHALL be returned on ls_rvalid with ls_rdata=mem_rdata (ignored by LS).
REQ-013 mem_rvalid in IDLE SHALL be ignored, producing no rvalid.
REQ-014 A wait counter SHALL clear on grant and increment each BUSY cycle without mem_rvalid.
REQ-015 When the counter reaches TIMEOUT, the arbiter SHALL pulse the owner's rvalid with rerr=1 and rdata=0 and enter IDLE, with no new grant that cycle.
REQ-016 A subsequent stray mem_rvalid after a timeout SHALL be ignored per REQ-013.
REQ-017 Default priority SHALL be fixed: LS wins when if_req and ls_req are both asserted.
REQ-018 Outside a grant, mem_req=0 and mem_addr/mem_wdata/mem_be/mem_we=0.
REQ-019 The non-owner's rvalid SHALL always be 0, and rdata outputs SHALL be 0 when rvalid=0.

Reset
REQ-020 Asynchronous reset SHALL force state=IDLE, owner=IF, counter=0 and the round-robin pointer=IF.
REQ-021 All registered state SHALL be reset as in REQ-020, so that all outputs are 0 while rst_n=0.
REQ-022 A transaction outstanding at reset SHALL be dropped, and its late mem_rvalid ignored.

Configuration
REQ-023 Macro ARB_RR_EN SHALL select the arbitration policy.
REQ-024 With ARB_RR_EN defined, contention SHALL be resolved round-robin:
- a 1-bit pointer names the last-granted requester;
- the other requester wins on a tie;
- the pointer updates on every grant.
REQ-025 Without ARB_RR_EN, fixed LS priority (REQ-017) SHALL apply and no pointer flop SHALL exist.

Structure
REQ-026 Shared package riscv_pkg SHALL hold the state enum (IDLE, BUSY) and the owner enum (OWN_IF, OWN_LS).
REQ-027 The arbitration decision (req pair plus pointer to one-hot grant) SHALL be sub-module arb_pick; the FSM, counter and muxes live in mem_arbiter.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- IF read only: if_req=1 at 0x0000_0010; mem_rvalid one cycle later with 0xDEAD_BEEF -> if_gnt in cycle 0, if_rvalid with 0xDEAD_BEEF in cycle 1, ls_rvalid=0.
- Contention, fixed priority: both req every cycle, memory latency 1 -> ls_gnt every issue cycle and if_gnt never; back-to-back grants with no idle cycle.
- Contention with ARB_RR_EN: both req continuously -> grants alternate LS, IF, LS, IF after reset (pointer=IF); each rvalid routed to the correct owner.
- Store: ls_we=1, ls_be=4'b0011, addr 0x100, wdata 0x1234_5678 -> mem_we=1, mem_be=4'b0011 and ls_rvalid on mem_rvalid.
- Timeout: TIMEOUT=4, mem_rvalid withheld -> owner rvalid with rerr=1 exactly 4 cycles after grant; a later mem_rvalid produces no rvalid.
- Reset mid-BUSY: rst_n low for 1 cycle after grant, then mem_rvalid -> no rvalid, state IDLE, next if_req granted immediately.
